// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared defaults and packed-port slice helper for the ROB RAM
package rob_pkg;

  localparam int ROB_WIDTH = 8;
  localparam int ROB_ADDR  = 4;
  localparam int ROB_NWR   = 2;
  localparam int ROB_NRD   = 3;

  // Base bit of port `port` inside a packed bus of `w`-bit fields.
  function automatic int port_lsb(input int port, input int w);
    return port * w;
  endfunction

endpackage

// File: rtl/rob_bypass_mux.sv
// rtl/rob_bypass_mux.sv - per-read-port forwarding of same-cycle writes
module rob_bypass_mux
  import rob_pkg::*;
#(
  parameter int WIDTH = ROB_WIDTH,
  parameter int ADDR  = ROB_ADDR,
  parameter int NWR   = ROB_NWR
) (
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*ADDR-1:0]  wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic [ADDR-1:0]      rd_addr,
  input  logic [WIDTH-1:0]     mem_data,
  input  logic                 mem_vld,
  input  logic                 flush,
  output logic [WIDTH-1:0]     data,
  output logic                 vld
);

  // Ascending scan so the highest-index matching port is the one left standing.
  always_comb begin
    data = mem_data;
    vld  = mem_vld & ~flush;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && wr_addr[port_lsb(p, ADDR) +: ADDR] == rd_addr) begin
        data = wr_data[port_lsb(p, WIDTH) +: WIDTH];
        vld  = ~flush;
      end
    end
  end

endmodule

// File: rtl/rob_mp_ram.sv
// rtl/rob_mp_ram.sv - multi-port ROB storage with valid bits, retire and flush
// ROB_RAM_BYPASS_EN: forward same-cycle write data to matching reads.
module rob_mp_ram
  import rob_pkg::*;
#(
  parameter int WIDTH = ROB_WIDTH,
  parameter int ADDR  = ROB_ADDR,
  parameter int NWR   = ROB_NWR,
  parameter int NRD   = ROB_NRD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*ADDR-1:0]  wr_addr,
  input  logic [NWR*WIDTH-1:0] wr_data,
  input  logic                 clr_en,
  input  logic [ADDR-1:0]      clr_addr,
  input  logic                 flush,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*ADDR-1:0]  rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_vld,
  output logic                 wr_conflict
);

  localparam int DEPTH = 2 ** ADDR;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_next;
  logic             conflict;
  logic [WIDTH-1:0] rdata [NRD];
  logic             rvld  [NRD];

  // Data array is never reset; a reset cycle simply drops its writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p])
          mem[wr_addr[port_lsb(p, ADDR) +: ADDR]] <= wr_data[port_lsb(p, WIDTH) +: WIDTH];
      end
    end
  end

  // Priority low to high: clear, writes, flush.
  always_comb begin
    vld_next = vld_q;
    if (clr_en)
      vld_next[clr_addr] = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p])
        vld_next[wr_addr[port_lsb(p, ADDR) +: ADDR]] = 1'b1;
    end
    if (flush)
      vld_next = '0;
  end

  always_comb begin
    conflict = 1'b0;
    for (int a = 0; a < NWR; a++) begin
      for (int b = a + 1; b < NWR; b++) begin
        if (wr_en[a] && wr_en[b] &&
            wr_addr[port_lsb(a, ADDR) +: ADDR] == wr_addr[port_lsb(b, ADDR) +: ADDR])
          conflict = 1'b1;
      end
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [ADDR-1:0] ra;
    assign ra = rd_addr[r*ADDR +: ADDR];
`ifdef ROB_RAM_BYPASS_EN
    rob_bypass_mux #(
      .WIDTH (WIDTH),
      .ADDR  (ADDR),
      .NWR   (NWR)
    ) u_bypass (
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (ra),
      .mem_data (mem[ra]),
      .mem_vld  (vld_q[ra]),
      .flush    (flush),
      .data     (rdata[r]),
      .vld      (rvld[r])
    );
`else
    assign rdata[r] = mem[ra];
    assign rvld[r]  = vld_q[ra] & ~flush;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      rd_data     <= '0;
      rd_vld      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      vld_q       <= vld_next;
      wr_conflict <= conflict;
      for (int r = 0; r < NRD; r++) begin
        if (rd_en[r]) begin
          rd_data[r*WIDTH +: WIDTH] <= rdata[r];
          rd_vld[r]                 <= rvld[r];
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_mp_ram.sv
// tb/tb_rob_mp_ram.sv - directed self-checking bench for rob_mp_ram
module tb_rob_mp_ram;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        clr_en;
  logic [3:0]  clr_addr;
  logic        flush;
  logic [2:0]  rd_en;
  logic [11:0] rd_addr;
  logic [23:0] rd_data;
  logic [2:0]  rd_vld;
  logic        wr_conflict;

  int checks = 0;
  int errors = 0;

  rob_mp_ram #(.WIDTH(8), .ADDR(4), .NWR(2), .NRD(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clr_en      (clr_en),
    .clr_addr    (clr_addr),
    .flush       (flush),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    clr_en = 1'b0; clr_addr = '0; flush = 1'b0; rd_en = '0; rd_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    // Known contents for the whole array; data survives the following reset.
    for (int a = 0; a < 8; a++) begin
      idle();
      wr_en = 2'b11; wr_addr = {4'(a + 8), 4'(a)}; wr_data = 16'h0000;
      step();
    end
    idle(); reset = 1'b1; step();
    idle(); step();
    check("post_reset_data", {8'h0, rd_data}, 32'h0);
    check("post_reset_vld", {29'h0, rd_vld}, 32'h0);
    check("post_reset_conflict", {31'h0, wr_conflict}, 32'h0);

    // Reads after reset: data zero, nothing valid
    idle(); rd_en = 3'b111; rd_addr = {4'd15, 4'd5, 4'd0}; step();
    check("rd_after_reset_data", {8'h0, rd_data}, 32'h0);
    check("rd_after_reset_vld", {29'h0, rd_vld}, 32'h0);
    check("rd_after_reset_conflict", {31'h0, wr_conflict}, 32'h0);

    // Write then read one cycle later
    idle(); wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_data = {8'h00, 8'hA5}; step();
    check("single_write_no_conflict", {31'h0, wr_conflict}, 32'h0);
    idle(); rd_en = 3'b010; rd_addr = {4'd0, 4'd3, 4'd0}; step();
    check("rd1_data_a5", {24'h0, rd_data[15:8]}, 32'hA5);
    check("rd1_vld", {31'h0, rd_vld[1]}, 32'h1);
    idle(); rd_addr = {4'd0, 4'd9, 4'd0}; step();
    check("rd1_hold_data", {24'h0, rd_data[15:8]}, 32'hA5);
    check("rd1_hold_vld", {31'h0, rd_vld[1]}, 32'h1);

    // Same-address writes: port 1 wins, conflict flagged for one cycle
    idle(); wr_en = 2'b11; wr_addr = {4'd7, 4'd7}; wr_data = {8'h22, 8'h11}; step();
    check("conflict_set", {31'h0, wr_conflict}, 32'h1);
    idle(); rd_en = 3'b100; rd_addr = {4'd7, 4'd0, 4'd0}; step();
    check("conflict_clear", {31'h0, wr_conflict}, 32'h0);
    check("conflict_winner", {24'h0, rd_data[23:16]}, 32'h22);
    check("conflict_winner_vld", {31'h0, rd_vld[2]}, 32'h1);

    // Read of an address written in the same cycle
    idle(); wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = {8'h00, 8'h3C};
    rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd9}; step();
`ifdef ROB_RAM_BYPASS_EN
    check("same_cycle_rd_data", {24'h0, rd_data[7:0]}, 32'h3C);
    check("same_cycle_rd_vld", {31'h0, rd_vld[0]}, 32'h1);
`else
    check("same_cycle_rd_data", {24'h0, rd_data[7:0]}, 32'h00);
    check("same_cycle_rd_vld", {31'h0, rd_vld[0]}, 32'h0);
`endif
    idle(); rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd9}; step();
    check("later_rd_data", {24'h0, rd_data[7:0]}, 32'h3C);
    check("later_rd_vld", {31'h0, rd_vld[0]}, 32'h1);

    // Retire versus write
    idle(); wr_en = 2'b11; wr_addr = {4'd2, 4'd1}; wr_data = {8'h42, 8'h41}; step();
    idle(); clr_en = 1'b1; clr_addr = 4'd1;
    wr_en = 2'b10; wr_addr = {4'd2, 4'd0}; wr_data = {8'h52, 8'h00}; step();
    idle(); clr_en = 1'b1; clr_addr = 4'd5;
    wr_en = 2'b01; wr_addr = {4'd0, 4'd5}; wr_data = {8'h00, 8'h55}; step();
    idle(); rd_en = 3'b111; rd_addr = {4'd5, 4'd2, 4'd1}; step();
    check("clr_data_kept", {8'h0, rd_data}, 32'h00_55_52_41);
    check("clr_and_write_vld", {29'h0, rd_vld}, 32'b110);

    // Flush overrides a same-cycle write; reads in that cycle see invalid
    idle(); flush = 1'b1; wr_en = 2'b01; wr_addr = {4'd0, 4'd4}; wr_data = {8'h00, 8'h77};
    rd_en = 3'b100; rd_addr = {4'd3, 4'd0, 4'd0}; step();
    check("flush_cycle_rd", {23'h0, rd_vld[2], rd_data[23:16]}, 32'h0A5);
    idle(); rd_en = 3'b111; rd_addr = {4'd7, 4'd3, 4'd4}; step();
    check("post_flush_data", {8'h0, rd_data}, 32'h00_22_A5_77);
    check("post_flush_vld", {29'h0, rd_vld}, 32'b000);

    // Reset in the middle of activity
    idle(); wr_en = 2'b11; wr_addr = {4'd8, 4'd8}; wr_data = {8'h02, 8'h01};
    rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd3}; step();
    check("pre_reset_state", {23'h0, wr_conflict, rd_data[7:0]}, 32'h1A5);
    idle(); reset = 1'b1; wr_en = 2'b01; wr_addr = {4'd0, 4'd6}; wr_data = {8'h00, 8'hFF};
    rd_en = 3'b111; rd_addr = {4'd6, 4'd6, 4'd6}; step();
    check("mid_reset_data", {8'h0, rd_data}, 32'h0);
    check("mid_reset_vld_conflict", {28'h0, wr_conflict, rd_vld}, 32'h0);
    idle(); step();
    check("reset_hold_data", {8'h0, rd_data}, 32'h0);
    idle(); rd_en = 3'b011; rd_addr = {4'd0, 4'd8, 4'd6}; step();
    check("reset_dropped_write", {8'h0, rd_data}, 32'h00_02_00);
    check("reset_cleared_vld", {29'h0, rd_vld}, 32'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_mp_ram.md
ROB_MP_RAM -- requirements
Module: rob_mp_ram

Interface
REQ-001 Parameter WIDTH, default 8, data bits per entry.
REQ-002 Parameter ADDR, default 4, address bits; DEPTH = 2**ADDR entries.
REQ-003 Parameter NWR, default 2, write ports (1..4).
REQ-004 Parameter NRD, default 3, read ports (1..6).
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 wr_en  in  NWR  per-port write strobe.
REQ-008 wr_addr  in  NWR*ADDR  packed write addresses, port p at bits [p*ADDR +: ADDR].
REQ-009 wr_data  in  NWR*WIDTH  packed write data, port p at bits [p*WIDTH +: WIDTH].
REQ-010 clr_en  in  1  retire strobe; invalidates entry clr_addr.
REQ-011 clr_addr  in  ADDR  entry to invalidate.
REQ-012 flush  in  1  invalidates all entries.
REQ-013 rd_en  in  NRD  per-port read strobe.
REQ-014 rd_addr  in  NRD*ADDR  packed read addresses.
REQ-015 rd_data  out  NRD*WIDTH  packed registered read data.
REQ-016 rd_vld  out  NRD  registered valid bit of the entry read.
REQ-017 wr_conflict  out  1  registered flag: two or more enabled write ports hit the same address in the previous cycle.

Function
REQ-018 Storage SHALL be DEPTH x WIDTH data plus one valid bit per entry.
REQ-019 A write on port p with wr_en[p]=1 SHALL update the entry at the next posedge and set its valid bit.
REQ-020 Same-address writes in one cycle: highest-index port SHALL win; wr_conflict SHALL be 1 the following cycle, else 0.
REQ-021 Read latency SHALL be exactly 1 cycle: rd_en[r] sampled at edge t, rd_data/rd_vld for port r valid after edge t.
REQ-022 rd_en[r]=0 SHALL hold port r's rd_data and rd_vld unchanged.
REQ-023 clr_en SHALL clear the valid bit of clr_addr; data SHALL be retained.
REQ-024 Write and clr_en to the same address in one cycle: write SHALL win (valid=1).
REQ-025 flush SHALL clear every valid bit in one cycle and SHALL override any same-cycle write or clear (all valid=0 next cycle; write data still stored).
REQ-026 Reads in a flush cycle SHALL return rd_vld=0.
REQ-027 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-028 reset=1 at a posedge SHALL clear all valid bits, rd_data, rd_vld and wr_conflict to 0; data array SHALL NOT be cleared.
REQ-029 reset SHALL take priority over flush, clr_en, wr_en and rd_en in the same cycle; writes in that cycle SHALL be discarded.
REQ-030 All outputs SHALL be 0 in the first cycle after reset deasserts.

Configuration
REQ-031 Macro ROB_RAM_BYPASS_EN defined: a read of an address written in the same cycle SHALL return the new data (winning port per REQ-020) and rd_vld=1 (rd_vld=0 if flush also asserted).
REQ-032 ROB_RAM_BYPASS_EN undefined: such a read SHALL return the pre-write data and pre-write valid bit; no forwarding logic present.

Structure
REQ-033 Shared package rob_pkg SHALL hold ROB_WIDTH/ROB_ADDR defaults and the packed-port index helper constants.
REQ-034 Per-read-port forwarding mux SHALL be sub-module rob_bypass_mux, instantiated NRD times, present only under ROB_RAM_BYPASS_EN.

Verification (WIDTH=8, ADDR=4, NWR=2, NRD=3)
REQ-035 Reset, then rd_en=3'b111 addr 0,5,15 -> rd_data all 0x00, rd_vld=3'b000, wr_conflict=0.
REQ-036 Write p0 addr3=0xA5, next cycle read port1 addr3 -> rd_data[1]=0xA5, rd_vld[1]=1 one cycle after rd_en.
REQ-037 Same cycle p0 addr7=0x11, p1 addr7=0x22 -> wr_conflict=1 next cycle; later read addr7 -> 0x22.
REQ-038 Same cycle write p0 addr9=0x3C and read port0 addr9 -> with ROB_RAM_BYPASS_EN 0x3C/vld 1; without, prior 0x00/vld 0.
REQ-039 Fill addr1,2 valid; clr_en addr1 with write p1 addr2 -> addr1 vld 0 data kept, addr2 vld 1; then flush with write addr4=0x77 -> all vld 0, addr4 data reads 0x77.
REQ-040 Assert reset mid-burst while writing addr6=0xFF -> outputs 0 next cycle, addr6 vld 0, rd_data holds 0x00 until a new read.
